// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the HI/LO divide sequencer.
//   div_state_e : controller state encoding (3 bits)
//   DIV_ITERS   : restoring iterations per divide (one per quotient bit)
//   CNT_W       : width of the iteration counter
package div_sequencer_pkg;

   typedef enum logic [2:0] {
      DIV_IDLE = 3'd0,
      DIV_PREP = 3'd1,
      DIV_RUN  = 3'd2,
      DIV_FIX  = 3'd3,
      DIV_DONE = 3'd4
   } div_state_e;

   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = $clog2(DIV_ITERS);

endpackage

// File: rtl/div_step.sv
// One restoring-divide iteration, purely combinational.
//   rem      in  WIDTH  partial remainder (always < divisor)
//   quo      in  WIDTH  dividend bits still to shift in / quotient bits so far
//   divisor  in  WIDTH  divisor magnitude, non-zero
//   rem_next out WIDTH  remainder after this step
//   quo_next out WIDTH  quotient after this step
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] trial;

   // rem < divisor, so the shifted remainder fits WIDTH+1 bits and the
   // top bit of the difference is a clean sign bit.
   always_comb begin
      rem_sh = {rem, quo[WIDTH-1]};
      trial  = rem_sh - {1'b0, divisor};
      if (!trial[WIDTH]) begin
         rem_next = trial[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = rem_sh[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU controller for the HI/LO divide resource.
//   clock        in   clock, all state updates on posedge
//   reset        in   asynchronous active-high reset
//   start        in   divide request, held until accepted
//   is_signed    in   1 = DIV, 0 = DIVU (sampled on accept)
//   dividend     in   rs value (sampled on accept)
//   divisor      in   rt value (sampled on accept)
//   mf_op_in_d   in   MFHI/MFLO in decode
//   busy         out  divide in PREP, RUN or FIX
//   stall        out  busy & (start | mf_op_in_d)
//   done         out  one-cycle HI/LO write enable
//   hi_out       out  remainder, held until next done
//   lo_out       out  quotient, held until next done
//   div_by_zero  out  current result came from a zero divisor
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DIV_IDLE | waiting for a request
// DIV_PREP | load magnitudes, short-circuit a zero divisor
// DIV_RUN  | one restoring step per cycle, 32 steps
// DIV_FIX  | apply result signs, register hi_out/lo_out
// DIV_DONE | done pulse; may accept the next request
module div_sequencer
   import div_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             mf_op_in_d,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_by_zero
);

   div_state_e       state, state_next;
   logic             accept;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] op_a, op_b;
   logic             sgn, neg_q, neg_r;
   logic [WIDTH-1:0] rem, quo, dvs;
   logic [WIDTH-1:0] rem_step, quo_step;

   // 0x80000000 negates to itself, which reads correctly as unsigned.
   function automatic logic [WIDTH-1:0] mag(input logic s, input logic [WIDTH-1:0] x);
      return (s && x[WIDTH-1]) ? -x : x;
   endfunction

   assign busy   = (state == DIV_PREP) || (state == DIV_RUN) || (state == DIV_FIX);
   assign done   = (state == DIV_DONE);
   assign accept = start & ~busy;
   assign stall  = busy & (start | mf_op_in_d);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= DIV_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         DIV_IDLE: if (accept) state_next = DIV_PREP;
         DIV_PREP: state_next = (op_b == '0) ? DIV_DONE : DIV_RUN;
         DIV_RUN:  if (cnt == '0) state_next = DIV_FIX;
         DIV_FIX:  state_next = DIV_DONE;
         DIV_DONE: state_next = accept ? DIV_PREP : DIV_IDLE;
         default:  state_next = DIV_IDLE;
      endcase
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (dvs),
      .rem_next (rem_step),
      .quo_next (quo_step)
   );

   // cnt is a down-counter: loaded with DIV_ITERS-1 in PREP, the step
   // taken while it reads zero is the last one.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         op_a        <= '0;
         op_b        <= '0;
         sgn         <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         rem         <= '0;
         quo         <= '0;
         dvs         <= '0;
         hi_out      <= '0;
         lo_out      <= '0;
         div_by_zero <= 1'b0;
      end else begin
         if (accept) begin
            op_a  <= dividend;
            op_b  <= divisor;
            sgn   <= is_signed;
            neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= is_signed & dividend[WIDTH-1];
         end
         case (state)
            DIV_PREP: begin
               rem <= '0;
               quo <= mag(sgn, op_a);
               dvs <= mag(sgn, op_b);
               cnt <= CNT_W'(DIV_ITERS - 1);
               if (op_b == '0) begin
                  hi_out      <= op_a;
                  lo_out      <= '1;
                  div_by_zero <= 1'b1;
               end
            end
            DIV_RUN: begin
               rem <= rem_step;
               quo <= quo_step;
               cnt <= cnt - CNT_W'(1);
            end
            DIV_FIX: begin
               lo_out      <= neg_q ? -quo : quo;
               hi_out      <= neg_r ? -rem : rem;
               div_by_zero <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
